// File: rtl/vending_fsm.sv
// -----------------------------------------------------------------------------
// vending_fsm
// Main control FSM of the vending machine. It accumulates coin credit in
// IDLE/SELECT, accepts a product choice on confirm (or returns money on
// cancel/timeout), then sequences a timed DISPENSE phase and a timed CHANGE
// phase. It drives the LED controller's state code, per-product enables and
// blink input.
//
// Ports
//   clk                       system clock, rising edge
//   rst_n                     synchronous active-low reset
//   coin_1/coin_5/coin_10     one-cycle coin pulses worth 1/5/10 units
//   sw_child/sw_men/sw_women  level product selection switches
//   btn_confirm/btn_cancel    one-cycle button pulses
//   state                     00 IDLE, 01 SELECT, 10 DISPENSE, 11 CHANGE
//   en_child/en_men/en_women  credit covers that product (SELECT only)
//   blink                     free-running square wave
//   credit                    current credit
//   dispense_*                one-cycle dispense pulse
//   change                    amount to return, valid while state==CHANGE
//   coin_reject               one-cycle pulse when offered coins are refused
// All outputs are registered.
// -----------------------------------------------------------------------------
module vending_fsm #(
   parameter int CREDIT_W        = 6,
   parameter int PRICE_CHILD     = 10,
   parameter int PRICE_MEN       = 15,
   parameter int PRICE_WOMEN     = 20,
   parameter int BLINK_DIV       = 25000000,
   parameter int DISPENSE_CYCLES = 50000000,
   parameter int CHANGE_CYCLES   = 50000000,
   parameter int TIMEOUT_CYCLES  = 500000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_1,
   input  logic                coin_5,
   input  logic                coin_10,
   input  logic                sw_child,
   input  logic                sw_men,
   input  logic                sw_women,
   input  logic                btn_confirm,
   input  logic                btn_cancel,
   output logic [1:0]          state,
   output logic                en_child,
   output logic                en_men,
   output logic                en_women,
   output logic                blink,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense_child,
   output logic                dispense_men,
   output logic                dispense_women,
   output logic [CREDIT_W-1:0] change,
   output logic                coin_reject
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_SELECT   = 2'b01,
      ST_DISPENSE = 2'b10,
      ST_CHANGE   = 2'b11
   } state_t;

   // One phase counter serves both timed states, so size it for the longer one.
   localparam int PH_MAX = (DISPENSE_CYCLES > CHANGE_CYCLES) ? DISPENSE_CYCLES : CHANGE_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BLK_W  = $clog2(BLINK_DIV + 1);

   localparam logic [PH_W-1:0]     DISP_LAST = PH_W'(DISPENSE_CYCLES - 1);
   localparam logic [PH_W-1:0]     CHG_LAST  = PH_W'(CHANGE_CYCLES - 1);
   localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLINK_DIV - 1);
   localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [CREDIT_W-1:0] P_CHILD   = CREDIT_W'(PRICE_CHILD);
   localparam logic [CREDIT_W-1:0] P_MEN     = CREDIT_W'(PRICE_MEN);
   localparam logic [CREDIT_W-1:0] P_WOMEN   = CREDIT_W'(PRICE_WOMEN);

   // Enable pattern {child, men, women} for a given credit.
   function automatic logic [2:0] en_mask(input logic [CREDIT_W-1:0] c);
      en_mask = {(c >= P_CHILD), (c >= P_MEN), (c >= P_WOMEN)};
   endfunction

   state_t              state_r;
   logic [CREDIT_W-1:0] credit_r;
   logic [CREDIT_W-1:0] change_r;
   logic [2:0]          en_r;
   logic [2:0]          dispense_r;
   logic [2:0]          prod_r;
   logic                coin_reject_r;
   logic                blink_r;
   logic [BLK_W-1:0]    blk_cnt_r;
   logic [PH_W-1:0]     ph_r;
   logic [TMO_W-1:0]    tmo_r;
   logic [2:0]          sw_prev_r;

   logic [4:0]          coin_val_s;
   logic                coin_any_s;
   logic [CREDIT_W:0]   sum_s;
   logic                fits_s;
   logic [CREDIT_W-1:0] credit_add_s;
   logic [CREDIT_W-1:0] coin_acc_s;
   logic [2:0]          sw_s;
   logic                activity_s;
   logic [2:0]          pick_s;
   logic [CREDIT_W-1:0] price_s;
   logic                coin_reject_s;
   logic [PH_W-1:0]     ph_inc_s;

   // Coin value, overflow check and credit after accepting this cycle's coins.
   always_comb begin
      coin_val_s   = (coin_1 ? 5'd1 : 5'd0) + (coin_5 ? 5'd5 : 5'd0) + (coin_10 ? 5'd10 : 5'd0);
      coin_any_s   = (coin_val_s != 5'd0);
      sum_s        = {1'b0, credit_r} + (CREDIT_W+1)'(coin_val_s);
      fits_s       = (sum_s <= CREDIT_MAX);
      if (fits_s) begin
         credit_add_s = sum_s[CREDIT_W-1:0];
         coin_acc_s   = CREDIT_W'(coin_val_s);
      end else begin
         credit_add_s = credit_r;
         coin_acc_s   = {CREDIT_W{1'b0}};
      end
      sw_s       = {sw_child, sw_men, sw_women};
      activity_s = coin_any_s | btn_confirm | btn_cancel | (sw_s != sw_prev_r);
      ph_inc_s   = ph_r + PH_W'(1);
   end

   // Product choice on confirm: child > men > women, switch on and enabled.
   // The registered enables reflect credit before this cycle's coins.
   always_comb begin
      if (sw_child && en_r[2]) begin
         pick_s  = 3'b100;
         price_s = P_CHILD;
      end else if (sw_men && en_r[1]) begin
         pick_s  = 3'b010;
         price_s = P_MEN;
      end else if (sw_women && en_r[0]) begin
         pick_s  = 3'b001;
         price_s = P_WOMEN;
      end else begin
         pick_s  = 3'b000;
         price_s = {CREDIT_W{1'b0}};
      end
   end

   // Coins are refused on overflow while collecting, and always while busy.
   always_comb begin
      case (state_r)
         ST_IDLE, ST_SELECT: coin_reject_s = coin_any_s & ~fits_s;
         default:            coin_reject_s = coin_any_s;
      endcase
   end

   // Main FSM, blink generator and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         credit_r      <= {CREDIT_W{1'b0}};
         change_r      <= {CREDIT_W{1'b0}};
         en_r          <= 3'b000;
         dispense_r    <= 3'b000;
         prod_r        <= 3'b000;
         coin_reject_r <= 1'b0;
         blink_r       <= 1'b0;
         blk_cnt_r     <= {BLK_W{1'b0}};
         ph_r          <= {PH_W{1'b0}};
         tmo_r         <= {TMO_W{1'b0}};
         sw_prev_r     <= 3'b000;
      end else begin
         if (blk_cnt_r == BLK_LAST) begin
            blk_cnt_r <= {BLK_W{1'b0}};
            blink_r   <= ~blink_r;
         end else begin
            blk_cnt_r <= blk_cnt_r + BLK_W'(1);
         end
         sw_prev_r     <= sw_s;
         coin_reject_r <= coin_reject_s;
         dispense_r    <= 3'b000;
         en_r          <= 3'b000;

         case (state_r)
            ST_IDLE: begin
               tmo_r <= {TMO_W{1'b0}};
               ph_r  <= {PH_W{1'b0}};
               if (coin_any_s && fits_s) begin
                  state_r  <= ST_SELECT;
                  credit_r <= credit_add_s;
                  en_r     <= en_mask(credit_add_s);
               end else begin
                  credit_r <= {CREDIT_W{1'b0}};
               end
            end
            ST_SELECT: begin
               if (btn_cancel) begin
                  // Money inserted alongside the cancel is returned as well.
                  state_r  <= ST_CHANGE;
                  change_r <= credit_add_s;
                  credit_r <= credit_add_s;
                  ph_r     <= {PH_W{1'b0}};
                  tmo_r    <= {TMO_W{1'b0}};
               end else if (btn_confirm && (pick_s != 3'b000)) begin
                  state_r  <= ST_DISPENSE;
                  prod_r   <= pick_s;
                  change_r <= credit_r - price_s + coin_acc_s;
                  ph_r     <= {PH_W{1'b0}};
                  tmo_r    <= {TMO_W{1'b0}};
                  // A one-cycle dispense phase fires its pulse immediately.
                  if (DISP_LAST == {PH_W{1'b0}}) begin
                     dispense_r <= pick_s;
                     credit_r   <= {CREDIT_W{1'b0}};
                  end else begin
                     credit_r   <= credit_add_s;
                  end
               end else if (!activity_s && (tmo_r == TMO_LAST)) begin
                  state_r  <= ST_CHANGE;
                  change_r <= credit_r;
                  ph_r     <= {PH_W{1'b0}};
                  tmo_r    <= {TMO_W{1'b0}};
               end else begin
                  credit_r <= credit_add_s;
                  en_r     <= en_mask(credit_add_s);
                  tmo_r    <= activity_s ? {TMO_W{1'b0}} : (tmo_r + TMO_W'(1));
               end
            end
            ST_DISPENSE: begin
               tmo_r <= {TMO_W{1'b0}};
               if (ph_r == DISP_LAST) begin
                  state_r  <= (change_r != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
                  ph_r     <= {PH_W{1'b0}};
                  credit_r <= {CREDIT_W{1'b0}};
               end else begin
                  ph_r <= ph_inc_s;
                  // Pulse and credit clear become visible in the last cycle.
                  if (ph_inc_s == DISP_LAST) begin
                     dispense_r <= prod_r;
                     credit_r   <= {CREDIT_W{1'b0}};
                  end else begin
                     dispense_r <= 3'b000;
                  end
               end
            end
            ST_CHANGE: begin
               tmo_r <= {TMO_W{1'b0}};
               if (ph_r == CHG_LAST) begin
                  state_r  <= ST_IDLE;
                  change_r <= {CREDIT_W{1'b0}};
                  credit_r <= {CREDIT_W{1'b0}};
                  ph_r     <= {PH_W{1'b0}};
               end else begin
                  ph_r <= ph_inc_s;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               credit_r <= {CREDIT_W{1'b0}};
               change_r <= {CREDIT_W{1'b0}};
               ph_r     <= {PH_W{1'b0}};
               tmo_r    <= {TMO_W{1'b0}};
            end
         endcase
      end
   end

   assign state          = state_r;
   assign en_child       = en_r[2];
   assign en_men         = en_r[1];
   assign en_women       = en_r[0];
   assign blink          = blink_r;
   assign credit         = credit_r;
   assign dispense_child = dispense_r[2];
   assign dispense_men   = dispense_r[1];
   assign dispense_women = dispense_r[0];
   assign change         = change_r;
   assign coin_reject    = coin_reject_r;

endmodule

// File: tb/tb_vending_fsm.sv
// -----------------------------------------------------------------------------
// tb_vending_fsm
// Drives vending_fsm with directed scenarios and random stimulus. A
// behavioural model (plain integers, count-down phase timers, blink derived
// from the cycle count since reset) predicts every output each cycle; a few
// hand-computed values pin the expected behaviour at key points.
// -----------------------------------------------------------------------------
module tb_vending_fsm;

   localparam int CW = 6;
   localparam int BD = 4;
   localparam int DC = 8;
   localparam int CC = 4;
   localparam int TO = 64;
   localparam int PC = 10;
   localparam int PM = 15;
   localparam int PW = 20;
   localparam int CMAX = 63;

   logic          clk = 1'b0;
   logic          rst_n, coin_1, coin_5, coin_10;
   logic          sw_child, sw_men, sw_women, btn_confirm, btn_cancel;
   logic [1:0]    state;
   logic          en_child, en_men, en_women, blink;
   logic [CW-1:0] credit, change;
   logic          dispense_child, dispense_men, dispense_women, coin_reject;

   int checks   = 0;
   int failures = 0;
   int disp_cnt = 0;

   // Model state: 0 idle, 1 select, 2 dispense, 3 change.
   int m_state, m_credit, m_change, m_prod, m_left, m_idle, m_cyc, m_rej, m_swprev;
   bit m_started = 1'b0;

   always #5 clk = ~clk;

   vending_fsm #(
      .CREDIT_W(CW), .PRICE_CHILD(PC), .PRICE_MEN(PM), .PRICE_WOMEN(PW),
      .BLINK_DIV(BD), .DISPENSE_CYCLES(DC), .CHANGE_CYCLES(CC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
      .sw_child(sw_child), .sw_men(sw_men), .sw_women(sw_women),
      .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
      .state(state), .en_child(en_child), .en_men(en_men), .en_women(en_women),
      .blink(blink), .credit(credit),
      .dispense_child(dispense_child), .dispense_men(dispense_men), .dispense_women(dispense_women),
      .change(change), .coin_reject(coin_reject)
   );

   task automatic model_step();
      int v, sw, add, p, price;
      v  = (coin_1 ? 1 : 0) + (coin_5 ? 5 : 0) + (coin_10 ? 10 : 0);
      sw = (sw_child ? 4 : 0) + (sw_men ? 2 : 0) + (sw_women ? 1 : 0);
      m_rej = 0;
      if (!rst_n) begin
         m_state = 0; m_credit = 0; m_change = 0; m_prod = 0; m_left = 0;
         m_idle = 0; m_cyc = 0; m_swprev = 0; m_started = 1'b1;
      end else begin
         m_cyc++;
         case (m_state)
            0: if (v > 0) begin
                  if (v <= CMAX) begin m_state = 1; m_credit = v; m_idle = 0; end
                  else m_rej = 1;
               end
            1: begin
                  add = (m_credit + v <= CMAX) ? v : 0;
                  if (v > 0 && m_credit + v > CMAX) m_rej = 1;
                  p = 0; price = 0;
                  if (sw_child && m_credit >= PC)      begin p = 1; price = PC; end
                  else if (sw_men && m_credit >= PM)   begin p = 2; price = PM; end
                  else if (sw_women && m_credit >= PW) begin p = 3; price = PW; end
                  if (btn_cancel) begin
                     m_credit += add; m_change = m_credit; m_state = 3; m_left = CC;
                  end else if (btn_confirm && p != 0) begin
                     m_change = m_credit - price + add; m_credit += add;
                     m_prod = p; m_state = 2; m_left = DC;
                  end else begin
                     m_credit += add;
                     if (v > 0 || btn_confirm || sw != m_swprev) m_idle = 0;
                     else begin
                        m_idle++;
                        if (m_idle == TO) begin
                           m_state = 3; m_change = m_credit; m_left = CC; m_idle = 0;
                        end
                     end
                  end
               end
            2: begin
                  if (v > 0) m_rej = 1;
                  m_left--;
                  if (m_left == 0) begin
                     m_credit = 0;
                     if (m_change > 0) begin m_state = 3; m_left = CC; end
                     else m_state = 0;
                  end
               end
            default: begin
                  if (v > 0) m_rej = 1;
                  m_left--;
                  if (m_left == 0) begin m_state = 0; m_change = 0; m_credit = 0; end
               end
         endcase
         m_swprev = sw;
      end
   endtask

   // Expected outputs: {state, en[3], blink, credit, dispense[3], change, reject}
   function automatic logic [21:0] exp_vec();
      logic [2:0] en, d;
      logic       last;
      int         cr, bl, st, ch, rj;
      last = (m_state == 2) && (m_left == 1);
      en   = (m_state == 1) ? {m_credit >= PC, m_credit >= PM, m_credit >= PW} : 3'b000;
      d    = !last ? 3'b000 : (m_prod == 1) ? 3'b100 : (m_prod == 2) ? 3'b010 : 3'b001;
      cr   = last ? 0 : m_credit;
      bl   = (m_cyc / BD) % 2;
      st = m_state; ch = m_change; rj = m_rej;
      exp_vec = {st[1:0], en, bl[0], cr[5:0], d, ch[5:0], rj[0]};
   endfunction

   function automatic logic [21:0] act_vec();
      act_vec = {state, en_child, en_men, en_women, blink, credit,
                 dispense_child, dispense_men, dispense_women, change, coin_reject};
   endfunction

   // One clock: model follows the edge, outputs are compared on the falling edge.
   task automatic tick();
      logic [21:0] e, a;
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_started) begin
         e = exp_vec();
         a = act_vec();
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL cycle_compare t=%0t actual=%h expected=%h", $time, a, e);
         end
         if (dispense_child || dispense_men || dispense_women) disp_cnt++;
      end
      coin_1 = 1'b0; coin_5 = 1'b0; coin_10 = 1'b0;
      btn_confirm = 1'b0; btn_cancel = 1'b0;
   endtask

   task automatic pin(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int d0;
      rst_n = 1'b0; coin_1 = 1'b0; coin_5 = 1'b0; coin_10 = 1'b0;
      sw_child = 1'b0; sw_men = 1'b0; sw_women = 1'b0;
      btn_confirm = 1'b0; btn_cancel = 1'b0;
      @(negedge clk);

      // Reset and idle
      tick(); tick(); rst_n = 1'b1;
      run(20);
      pin("idle_state", state, 0);
      pin("idle_credit", credit, 0);

      // 10+5, buy men product, no change
      coin_10 = 1'b1; tick(); coin_5 = 1'b1; tick();
      pin("c15_state", state, 1);
      pin("c15_credit", credit, 15);
      pin("c15_model_credit", m_credit, 15);
      pin("c15_en", {en_child, en_men, en_women}, 3'b110);
      d0 = disp_cnt;
      sw_men = 1'b1; btn_confirm = 1'b1; tick();
      pin("men_disp_state", state, 2);
      run(7);
      pin("men_last_state", state, 2);
      pin("men_pulse", dispense_men, 1);
      tick();
      pin("men_done_state", state, 0);
      pin("men_done_change", change, 0);
      pin("men_pulses", disp_cnt - d0, 1);

      // 20 credit, child beats women, change 10
      sw_men = 1'b0;
      coin_10 = 1'b1; tick(); coin_10 = 1'b1; tick();
      pin("c20_credit", credit, 20);
      d0 = disp_cnt;
      sw_child = 1'b1; sw_women = 1'b1; btn_confirm = 1'b1; tick();
      pin("child_state", state, 2);
      pin("child_change", change, 10);
      run(8);
      pin("child_chg_state", state, 3);
      pin("child_chg_value", change, 10);
      run(3);
      pin("child_chg_hold", state, 3);
      tick();
      pin("child_done_state", state, 0);
      pin("child_pulses", disp_cnt - d0, 1);

      // Unaffordable confirm ignored; cancel wins over confirm
      sw_child = 1'b0;
      coin_5 = 1'b1; tick();
      d0 = disp_cnt;
      btn_confirm = 1'b1; tick();
      pin("ignored_state", state, 1);
      pin("ignored_credit", credit, 5);
      btn_confirm = 1'b1; btn_cancel = 1'b1; tick();
      pin("cancel_state", state, 3);
      pin("cancel_change", change, 5);
      run(4);
      pin("cancel_done_state", state, 0);
      pin("cancel_pulses", disp_cnt - d0, 0);

      // Overflow reject at 58, coin during DISPENSE
      sw_women = 1'b0;
      for (int i = 0; i < 5; i++) begin coin_10 = 1'b1; tick(); end
      coin_5 = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin coin_1 = 1'b1; tick(); end
      pin("c58_credit", credit, 58);
      coin_10 = 1'b1; tick();
      pin("ovf_reject", coin_reject, 1);
      pin("ovf_credit", credit, 58);
      tick();
      pin("ovf_reject_clear", coin_reject, 0);
      sw_child = 1'b1; btn_confirm = 1'b1; tick();
      pin("c58_change", change, 48);
      coin_10 = 1'b1; tick();
      pin("busy_reject", coin_reject, 1);
      pin("busy_change", change, 48);
      run(12);
      pin("c58_done_state", state, 0);

      // Timeout after 64 idle cycles in SELECT
      sw_child = 1'b0;
      coin_5 = 1'b1; tick();
      run(TO - 1);
      pin("tmo_pre_state", state, 1);
      tick();
      pin("tmo_state", state, 3);
      pin("tmo_change", change, 5);
      run(4);
      pin("tmo_done_state", state, 0);

      // Reset in the middle of DISPENSE
      coin_10 = 1'b1; tick();
      sw_child = 1'b1; btn_confirm = 1'b1; tick();
      pin("rst_pre_state", state, 2);
      d0 = disp_cnt;
      run(3);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      pin("rst_state", state, 0);
      pin("rst_credit", credit, 0);
      pin("rst_change", change, 0);
      sw_child = 1'b0;
      run(10);
      pin("rst_pulses", disp_cnt - d0, 0);

      // Random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         if (i % 700 == 350) begin
            run(TO + 10);
         end else begin
            coin_1      = ($urandom_range(0, 9) == 0);
            coin_5      = ($urandom_range(0, 9) == 0);
            coin_10     = ($urandom_range(0, 4) == 0);
            btn_confirm = ($urandom_range(0, 5) == 0);
            btn_cancel  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 11) == 0) sw_child = ~sw_child;
            if ($urandom_range(0, 11) == 0) sw_men   = ~sw_men;
            if ($urandom_range(0, 11) == 0) sw_women = ~sw_women;
            rst_n = ($urandom_range(0, 799) != 0);
            tick();
            rst_n = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vending_fsm.md
Name: vending_fsm

Overview:
Main control FSM of the vending machine. It sits directly upstream of the LED controller and drives that controller's state code, per-product enables and blink inputs. It accumulates coin credit and accepts a product selection with confirm or cancel. It then sequences dispense and change-return, and reports credit, dispense pulses and change.

Parameters:
CREDIT_W, 6, width of the credit and change counters (in coin units)
PRICE_CHILD, 10, price of the child product (coin units)
PRICE_MEN, 15, price of the men product
PRICE_WOMEN, 20, price of the women product
BLINK_DIV, 25000000, half-period of blink in clk cycles
DISPENSE_CYCLES, 50000000, clk cycles spent in DISPENSE
CHANGE_CYCLES, 50000000, clk cycles spent in CHANGE
TIMEOUT_CYCLES, 500000000, idle cycles in SELECT before auto-cancel

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
coin_1, coin_5, coin_10  in  1 each  one-cycle pulses worth 1, 5 and 10 units (already synchronised/debounced)
sw_child, sw_men, sw_women  in  1 each  level selection switches
btn_confirm, btn_cancel  in  1 each  one-cycle pulses
state  out  2  00 IDLE, 01 SELECT, 10 DISPENSE, 11 CHANGE
en_child, en_men, en_women  out  1 each  credit >= that product's price (SELECT only)
blink  out  1  free-running square wave
credit  out  CREDIT_W  current credit
dispense_child, dispense_men, dispense_women  out  1 each  one-cycle dispense pulse
change  out  CREDIT_W  amount to return, valid while state==CHANGE
coin_reject  out  1  one-cycle pulse when offered coins are refused

Behaviour:
- Reset (rst_n low at posedge clk): state=IDLE, credit=0, change=0, blink=0, all timers 0. All en_*, dispense_* and coin_reject are 0.
- Reset mid-operation aborts immediately. No dispense pulse and no change are issued.
- All outputs are registered. Coin value is the sum of all coin_* asserted in the same cycle (0..16).
- Coin acceptance (IDLE/SELECT only):
  - If credit + value <= 2^CREDIT_W-1, credit += value on the next edge.
  - Otherwise credit is unchanged and coin_reject pulses for 1 cycle.
  - Any coin in DISPENSE or CHANGE: rejected, coin_reject pulses.
- en_x = (state==SELECT) && credit >= PRICE_x. en_x is 0 in all other states.
- blink: counter 0..BLINK_DIV-1. blink toggles on wrap and runs in every state.
- IDLE: credit is 0. An accepted coin (value > 0) moves to SELECT next cycle with credit=value.
- SELECT:
  - Timeout counter clears on any coin, btn_confirm, btn_cancel or sw_* change. It otherwise increments.
  - btn_cancel, or timeout reaching TIMEOUT_CYCLES -> CHANGE with change = credit.
  - btn_confirm: chosen product is the first of child > men > women whose sw_x=1 and en_x=1.
    - If one exists: latch it and go to DISPENSE. change = credit - price (using credit before any coin in the same cycle) + any same-cycle coin value.
    - If none exists: confirm is ignored and the FSM stays in SELECT.
  - btn_cancel and btn_confirm in the same cycle: cancel wins.
- DISPENSE: lasts exactly DISPENSE_CYCLES cycles.
  - On the last cycle, the latched dispense_x pulses for 1 cycle and credit becomes 0.
  - Next state is CHANGE if change > 0, else IDLE.
- CHANGE: change is held stable for exactly CHANGE_CYCLES cycles, then goes to IDLE with change=0 and credit=0. Inputs other than coins are ignored.
- Buttons and switches are ignored outside SELECT.
- Exactly one dispense_* pulse per purchase. Never a dispense pulse on a cancel or timeout path.

Test Plan:
Bench parameters: BLINK_DIV=4, DISPENSE_CYCLES=8, CHANGE_CYCLES=4, TIMEOUT_CYCLES=64, prices 10/15/20.
- Reset then idle 20 cycles -> state=00, credit=0, all outputs 0 except blink, which toggles every 4 cycles.
- coin_10, coin_5 -> state=01, credit=15, en_child=1, en_men=1, en_women=0. Then sw_men=1 + btn_confirm -> state=10 for 8 cycles, dispense_men pulses once, then state=00 (change=0).
- credit=20 via coin_10 ×2, sw_child=1, sw_women=1, confirm -> child dispensed, then state=11 with change=10 for 4 cycles, then 00.
- credit=5, sw_women=1, confirm -> ignored, stays 01. Then btn_cancel+btn_confirm in the same cycle -> state=11, change=5, no dispense pulse.
- credit=58, coin_10 -> coin_reject pulse, credit stays 58. A coin during DISPENSE -> coin_reject pulse, change unaffected.
- credit=5 with no activity for 64 cycles -> state=11, change=5. rst_n low mid-DISPENSE -> state=00 next edge, no dispense pulse.
